// File: rtl/hazard_unit.sv
// ---------------------------------------------------------------------------
// hazard_unit
//   Stall/flush and forwarding controller for the 5-stage MIPS pipeline.
//   Decides, every cycle, which pipeline registers hold (Stall*), which are
//   cleared to a bubble (Flush*), and where the EX and ID operands come from
//   (Forward*). It also sequences multi-cycle divides, tracks data-memory
//   wait time and applies the exception flush.
//
//   Ports
//     clk, rst                   clock (rising edge), synchronous active-high reset
//     RsD, RtD                   ID source registers
//     RsE, RtE                   EX source registers
//     WriteRegE/M/W, RegWriteE/M/W  destination register and write enable per stage
//     MemReadE/M                 stage holds a load
//     BranchD, JumpSrcD          branch / register-target jump in ID
//     DivStartE                  DIV/DIVU valid in EX
//     DataReqM, DataOkM          data-memory handshake in MEM
//     ExceptM                    exception taken in MEM
//     StallF/D/E/M               hold stage register
//     FlushD/E/M/W               clear stage register to a bubble
//     ForwardAE/BE               EX operand select: 00 regfile, 01 from W, 10 from M
//     ForwardAD/BD               ID compare operand from M
//     DivBusy, DivDoneE          divide sequencer active / one-cycle result-valid pulse
//     MemErr                     sticky data-memory timeout flag
//     dbgState                   divide sequencer state (0 IDLE, 1 DIV_RUN)
//
//   Data-memory handshake: MEM raises DataReqM for as long as an access is
//   outstanding; the access completes in the cycle DataOkM is high while
//   DataReqM is high. A cycle with DataReqM=1 and DataOkM=0 is a wait cycle,
//   and the whole front of the pipe (F..M) holds while W gets a bubble.
// ---------------------------------------------------------------------------
module hazard_unit #(
   parameter int DIV_CYCLES  = 36,
   parameter int MEM_TIMEOUT = 255
) (
   input  logic       clk,
   input  logic       rst,
   input  logic [4:0] RsD,
   input  logic [4:0] RtD,
   input  logic [4:0] RsE,
   input  logic [4:0] RtE,
   input  logic [4:0] WriteRegE,
   input  logic [4:0] WriteRegM,
   input  logic [4:0] WriteRegW,
   input  logic       RegWriteE,
   input  logic       RegWriteM,
   input  logic       RegWriteW,
   input  logic       MemReadE,
   input  logic       MemReadM,
   input  logic [1:0] BranchD,
   input  logic       JumpSrcD,
   input  logic       DivStartE,
   input  logic       DataReqM,
   input  logic       DataOkM,
   input  logic       ExceptM,
   output logic       StallF,
   output logic       StallD,
   output logic       StallE,
   output logic       StallM,
   output logic       FlushD,
   output logic       FlushE,
   output logic       FlushM,
   output logic       FlushW,
   output logic [1:0] ForwardAE,
   output logic [1:0] ForwardBE,
   output logic       ForwardAD,
   output logic       ForwardBD,
   output logic       DivBusy,
   output logic       DivDoneE,
   output logic       MemErr,
   output logic       dbgState
);

   localparam int CW = (DIV_CYCLES > 1) ? $clog2(DIV_CYCLES) : 1;
   localparam int WW = $clog2(MEM_TIMEOUT + 1);
   localparam logic [CW-1:0] DIV_LAST  = CW'(DIV_CYCLES - 1);
   localparam logic [WW-1:0] WAIT_MAX  = WW'(MEM_TIMEOUT);
   localparam logic [WW-1:0] WAIT_LAST = WW'(MEM_TIMEOUT - 1);

   typedef enum logic {
      IDLE    = 1'b0,
      DIV_RUN = 1'b1
   } divState_t;

   divState_t     state;
   logic [CW-1:0] divCnt;
   logic [WW-1:0] waitCnt;
   logic          memErrQ;

   logic lwStall;
   logic brStall;
   logic hazStall;
   logic memWait;
   logic divStall;
   logic divDone;

   // Hazard sources, before priority is applied.
   always_comb begin
      lwStall  = MemReadE && (WriteRegE != 5'd0) &&
                 ((WriteRegE == RsD) || (WriteRegE == RtD));
      // Branch/JR compare in ID needs the value now: an ALU result still in
      // EX or a load still in MEM cannot be forwarded in time.
      brStall  = ((|BranchD) || JumpSrcD) &&
                 ((RegWriteE && (WriteRegE != 5'd0) &&
                   ((WriteRegE == RsD) || (WriteRegE == RtD))) ||
                  (MemReadM && (WriteRegM != 5'd0) &&
                   ((WriteRegM == RsD) || (WriteRegM == RtD))));
      hazStall = lwStall || brStall;
      memWait  = DataReqM && !DataOkM;
      // The start cycle already stalls, so the total hold is DIV_CYCLES.
      divStall = ((state == IDLE) && DivStartE) ||
                 ((state == DIV_RUN) && (divCnt != '0));
      divDone  = (state == DIV_RUN) && (divCnt == '0) && !memWait;
   end

   // Outputs. Exception wins over everything; otherwise each stage stalls if
   // any source wants it, and a flush is dropped for a stage that a higher
   // source is holding (a held register must keep its instruction).
   always_comb begin
      StallF    = 1'b0;
      StallD    = 1'b0;
      StallE    = 1'b0;
      StallM    = 1'b0;
      FlushD    = 1'b0;
      FlushE    = 1'b0;
      FlushM    = 1'b0;
      FlushW    = 1'b0;
      ForwardAE = 2'b00;
      ForwardBE = 2'b00;
      ForwardAD = 1'b0;
      ForwardBD = 1'b0;
      DivBusy   = 1'b0;
      DivDoneE  = 1'b0;
      MemErr    = 1'b0;
      dbgState  = 1'b0;
      if (!rst) begin
         if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsE))
            ForwardAE = 2'b10;
         else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RsE))
            ForwardAE = 2'b01;
         if (RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtE))
            ForwardBE = 2'b10;
         else if (RegWriteW && (WriteRegW != 5'd0) && (WriteRegW == RtE))
            ForwardBE = 2'b01;
         ForwardAD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RsD);
         ForwardBD = RegWriteM && (WriteRegM != 5'd0) && (WriteRegM == RtD);
         DivBusy   = (state == DIV_RUN);
         MemErr    = memErrQ;
         dbgState  = (state == DIV_RUN);
         if (ExceptM) begin
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
            FlushW = 1'b1;
         end else begin
            StallM   = memWait;
            StallE   = memWait || divStall;
            StallD   = memWait || divStall || hazStall;
            StallF   = StallD;
            FlushW   = memWait;
            FlushM   = divStall && !StallM;
            FlushE   = hazStall && !StallE;
            DivDoneE = divDone;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state   <= IDLE;
         divCnt  <= '0;
         waitCnt <= '0;
         memErrQ <= 1'b0;
      end else begin
         // Wait-time watchdog; saturates so it cannot wrap back to zero.
         if (memWait) begin
            if (waitCnt != WAIT_MAX)
               waitCnt <= waitCnt + WW'(1);
            if (waitCnt >= WAIT_LAST)
               memErrQ <= 1'b1;
         end else begin
            waitCnt <= '0;
         end

         // The divider is frozen while memory holds the pipe.
         if (ExceptM) begin
            state  <= IDLE;
            divCnt <= '0;
         end else if (!memWait) begin
            case (state)
               IDLE: begin
                  if (DivStartE) begin
                     state  <= DIV_RUN;
                     divCnt <= DIV_LAST;
                  end
               end
               DIV_RUN: begin
                  if (divCnt != '0)
                     divCnt <= divCnt - CW'(1);
                  else
                     state <= IDLE;
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_hazard_unit.sv
// ---------------------------------------------------------------------------
// tb_hazard_unit
//   Directed bench for hazard_unit with DIV_CYCLES=4, MEM_TIMEOUT=5.
//   Inputs change 1 time unit after each rising edge; outputs are sampled
//   1 time unit later, well clear of the next edge.
// ---------------------------------------------------------------------------
module tb_hazard_unit;

   localparam int DIVC = 4;
   localparam int MTO  = 5;

   logic       clk = 1'b0;
   logic       rst;
   logic [4:0] RsD, RtD, RsE, RtE, WriteRegE, WriteRegM, WriteRegW;
   logic       RegWriteE, RegWriteM, RegWriteW, MemReadE, MemReadM;
   logic [1:0] BranchD;
   logic       JumpSrcD, DivStartE, DataReqM, DataOkM, ExceptM;
   logic       StallF, StallD, StallE, StallM;
   logic       FlushD, FlushE, FlushM, FlushW;
   logic [1:0] ForwardAE, ForwardBE;
   logic       ForwardAD, ForwardBD, DivBusy, DivDoneE, MemErr, dbgState;

   logic [3:0]  stalls;
   logic [3:0]  flushes;
   logic [17:0] allOut;
   logic [2:0]  divObs;

   int nChecks = 0;
   int nErrors = 0;
   logic [2:0] exp_q[$];

   assign stalls  = {StallF, StallD, StallE, StallM};
   assign flushes = {FlushD, FlushE, FlushM, FlushW};
   assign allOut  = {stalls, flushes, ForwardAE, ForwardBE, ForwardAD,
                     ForwardBD, DivBusy, DivDoneE, MemErr, dbgState};
   assign divObs  = {StallE, DivDoneE, DivBusy};

   hazard_unit #(.DIV_CYCLES(DIVC), .MEM_TIMEOUT(MTO)) dut (
      .clk(clk), .rst(rst),
      .RsD(RsD), .RtD(RtD), .RsE(RsE), .RtE(RtE),
      .WriteRegE(WriteRegE), .WriteRegM(WriteRegM), .WriteRegW(WriteRegW),
      .RegWriteE(RegWriteE), .RegWriteM(RegWriteM), .RegWriteW(RegWriteW),
      .MemReadE(MemReadE), .MemReadM(MemReadM),
      .BranchD(BranchD), .JumpSrcD(JumpSrcD), .DivStartE(DivStartE),
      .DataReqM(DataReqM), .DataOkM(DataOkM), .ExceptM(ExceptM),
      .StallF(StallF), .StallD(StallD), .StallE(StallE), .StallM(StallM),
      .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM), .FlushW(FlushW),
      .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
      .ForwardAD(ForwardAD), .ForwardBD(ForwardBD),
      .DivBusy(DivBusy), .DivDoneE(DivDoneE), .MemErr(MemErr),
      .dbgState(dbgState)
   );

   // Clock
   always #5 clk = ~clk;

   // Driver tasks
   task automatic clearInputs();
      RsD = '0; RtD = '0; RsE = '0; RtE = '0;
      WriteRegE = '0; WriteRegM = '0; WriteRegW = '0;
      RegWriteE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
      MemReadE = 1'b0; MemReadM = 1'b0; BranchD = 2'b00; JumpSrcD = 1'b0;
      DivStartE = 1'b0; DataReqM = 1'b0; DataOkM = 1'b0; ExceptM = 1'b0;
   endtask

   task automatic randomInputs();
      RsD = 5'($urandom_range(0, 31)); RtD = 5'($urandom_range(0, 31));
      RsE = 5'($urandom_range(0, 31)); RtE = 5'($urandom_range(0, 31));
      WriteRegE = 5'($urandom_range(0, 31));
      WriteRegM = 5'($urandom_range(0, 31));
      WriteRegW = 5'($urandom_range(0, 31));
      RegWriteE = 1'($urandom_range(0, 1)); RegWriteM = 1'($urandom_range(0, 1));
      RegWriteW = 1'($urandom_range(0, 1)); MemReadE = 1'($urandom_range(0, 1));
      MemReadM = 1'($urandom_range(0, 1)); BranchD = 2'($urandom_range(0, 3));
      JumpSrcD = 1'($urandom_range(0, 1)); DivStartE = 1'($urandom_range(0, 1));
      DataReqM = 1'($urandom_range(0, 1)); DataOkM = 1'($urandom_range(0, 1));
      ExceptM = 1'($urandom_range(0, 1));
   endtask

   task automatic nextCycle();
      @(posedge clk);
      #1;
   endtask

   task automatic settle();
      #1;
   endtask

   // Scoreboard comparison
   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      nChecks++;
      assert (obs === expv) else begin
         nErrors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   // Pops one expected {StallE, DivDoneE, DivBusy} triple per cycle.
   task automatic chkDivSeq(input string tag);
      logic [2:0] e;
      if (exp_q.size() == 0) begin
         nChecks++;
         nErrors++;
         $error("FAIL %s observed=empty expected=queue entry", tag);
      end else begin
         e = exp_q.pop_front();
         chk(tag, 32'(divObs), 32'(e));
      end
   endtask

   initial begin
      // Reset with random inputs: everything must read zero.
      rst = 1'b1;
      randomInputs();
      settle();
      chk("rst_cycle0", 32'(allOut), 32'h0);
      nextCycle();
      randomInputs();
      settle();
      chk("rst_cycle1", 32'(allOut), 32'h0);
      nextCycle();
      rst = 1'b0;
      clearInputs();
      settle();
      chk("post_rst_idle", 32'(allOut), 32'h0);

      // Load-use stall
      MemReadE = 1'b1; WriteRegE = 5'd8; RsD = 5'd8;
      settle();
      chk("lw_rs_stall", 32'(stalls), 32'b1100);
      chk("lw_rs_flush", 32'(flushes), 32'b0100);
      WriteRegE = 5'd0;
      settle();
      chk("lw_r0_stall", 32'(stalls), 32'b0000);
      chk("lw_r0_flush", 32'(flushes), 32'b0000);
      RsD = 5'd0; RtD = 5'd8; WriteRegE = 5'd8;
      settle();
      chk("lw_rt_stall", 32'(stalls), 32'b1100);

      // Branch stalls: ALU result in EX, load in MEM
      clearInputs();
      BranchD = 2'b01; RegWriteE = 1'b1; WriteRegE = 5'd9; RtD = 5'd9;
      settle();
      chk("br_ex_stall", 32'(stalls), 32'b1100);
      chk("br_ex_flush", 32'(flushes), 32'b0100);
      BranchD = 2'b00;
      settle();
      chk("nobr_ex", 32'(stalls), 32'b0000);
      clearInputs();
      JumpSrcD = 1'b1; MemReadM = 1'b1; WriteRegM = 5'd3; RsD = 5'd3;
      settle();
      chk("jr_mem_stall", 32'(stalls), 32'b1100);

      // Forwarding
      clearInputs();
      RegWriteM = 1'b1; RegWriteW = 1'b1; WriteRegM = 5'd5; WriteRegW = 5'd5;
      RsE = 5'd5; RtE = 5'd6;
      settle();
      chk("fwd_ae_m", 32'(ForwardAE), 32'b10);
      chk("fwd_be_none", 32'(ForwardBE), 32'b00);
      RegWriteM = 1'b0;
      settle();
      chk("fwd_ae_w", 32'(ForwardAE), 32'b01);
      RtE = 5'd5; RegWriteM = 1'b1;
      settle();
      chk("fwd_be_m", 32'(ForwardBE), 32'b10);
      clearInputs();
      RegWriteW = 1'b1; WriteRegW = 5'd0; RsE = 5'd0;
      settle();
      chk("fwd_r0", 32'(ForwardAE), 32'b00);
      clearInputs();
      RegWriteM = 1'b1; WriteRegM = 5'd7; RsD = 5'd7; RtD = 5'd2;
      settle();
      chk("fwd_ad", 32'({ForwardAD, ForwardBD}), 32'b10);
      chk("fwd_ad_nostall", 32'(stalls), 32'b0000);

      // Divide: start pulse at t, DivStartE re-asserted in the done cycle
      clearInputs();
      nextCycle();
      DivStartE = 1'b1;
      settle();
      chk("div_t_stall", 32'(stalls), 32'b1110);
      chk("div_t_flush", 32'(flushes), 32'b0010);
      chk("div_t_busy", 32'({DivBusy, DivDoneE}), 32'b00);
      exp_q = {3'b101, 3'b101, 3'b101, 3'b011};
      for (int i = 1; i <= 4; i++) begin
         nextCycle();
         DivStartE = (i == 4);
         settle();
         chkDivSeq($sformatf("div_t%0d", i));
      end
      nextCycle();
      DivStartE = 1'b0;
      settle();
      chk("div_t5_idle", 32'(allOut), 32'h0);

      // Divide interrupted by three memory wait cycles
      DivStartE = 1'b1;
      settle();
      nextCycle();
      DivStartE = 1'b0;
      settle();
      chk("divw_t1", 32'(divObs), 32'b101);
      for (int i = 2; i <= 4; i++) begin
         nextCycle();
         DataReqM = 1'b1; DataOkM = 1'b0;
         settle();
         chk($sformatf("divw_t%0d_stall", i), 32'(stalls), 32'b1111);
         chk($sformatf("divw_t%0d_flush", i), 32'(flushes), 32'b0001);
         chk($sformatf("divw_t%0d_done", i), 32'(DivDoneE), 32'b0);
      end
      exp_q = {3'b101, 3'b101, 3'b011, 3'b000};
      for (int i = 5; i <= 8; i++) begin
         nextCycle();
         DataReqM = 1'b0;
         settle();
         chkDivSeq($sformatf("divw_t%0d", i));
      end
      chk("divw_noerr", 32'(MemErr), 32'b0);

      // Divide killed by an exception at t+2
      DivStartE = 1'b1;
      settle();
      nextCycle();
      DivStartE = 1'b0;
      nextCycle();
      ExceptM = 1'b1;
      settle();
      chk("exc_stall", 32'(stalls), 32'b0000);
      chk("exc_flush", 32'(flushes), 32'b1111);
      chk("exc_done", 32'(DivDoneE), 32'b0);
      nextCycle();
      ExceptM = 1'b0;
      settle();
      chk("exc_t3_busy", 32'({DivBusy, dbgState}), 32'b00);
      chk("exc_t3_stall", 32'(stalls), 32'b0000);
      for (int i = 4; i <= 6; i++) begin
         nextCycle();
         chk($sformatf("exc_t%0d_nodone", i), 32'({DivBusy, DivDoneE}), 32'b00);
      end

      // Exception outranks a memory wait
      DataReqM = 1'b1; ExceptM = 1'b1;
      settle();
      chk("exc_over_wait", 32'({stalls, flushes}), 32'b0000_1111);
      nextCycle();
      clearInputs();
      nextCycle();

      // Memory timeout: MemErr after MTO wait cycles, sticky, stall continues
      DataReqM = 1'b1;
      for (int i = 1; i <= MTO; i++) begin
         settle();
         chk($sformatf("wait%0d_noerr", i), 32'({MemErr, StallM}), 32'b01);
         nextCycle();
      end
      settle();
      chk("timeout_err", 32'({MemErr, StallM, FlushW}), 32'b111);
      DataOkM = 1'b1;
      settle();
      chk("timeout_ok_nostall", 32'(stalls), 32'b0000);
      nextCycle();
      DataReqM = 1'b0; DataOkM = 1'b0;
      settle();
      chk("err_sticky", 32'(MemErr), 32'b1);

      // Reset mid-divide clears everything, including MemErr
      DivStartE = 1'b1;
      nextCycle();
      DivStartE = 1'b0;
      rst = 1'b1;
      settle();
      chk("rst_mid_div", 32'(allOut), 32'h0);
      nextCycle();
      rst = 1'b0;
      settle();
      chk("after_rst_mid_div", 32'(allOut), 32'h0);
      nextCycle();
      chk("after_rst_nodone", 32'(allOut), 32'h0);

      $display("Simulation finished: %0d checks, %0d errors", nChecks, nErrors);
      $finish;
   end

endmodule
